ysyx_23060184_fetch_pcgen: RTL and testbench
============================================

# ysyx_23060184_fetch_pcgen

Fetch-stage PC generator with instruction-fetch request tracking. It issues sequential fetch addresses to the IFU over a valid/ready request channel and records every issued PC in a small in-order FIFO. It pairs each returned instruction with its PC and forwards the pair to decode. On a branch/jump redirect, all in-flight fetches are squashed, and their late responses are silently drained.

## Interface
Parameters:
- ADDR_WIDTH, 32: width of all PC fields.
- RESET_PC, 32'h2000_0000: PC after reset; must be STEP-aligned.
- STEP, 4: sequential increment in bytes; power of two.
- DEPTH, 4: max outstanding fetches; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  IFU accepts request.
- req_pc  out  ADDR_WIDTH  fetch address.
- rsp_valid  in  1  IFU returns instruction, in request order.
- rsp_ready  out  1  block consumes response.
- rsp_inst  in  32  returned instruction.
- out_valid  out  1  instruction+PC valid to decode.
- out_ready  in  1  decode accepts.
- out_pc  out  ADDR_WIDTH  PC of out_inst.
- out_inst  out  32  instruction (rsp_inst passthrough).

## Operation
- State:
  - pc register.
  - PC FIFO of DEPTH entries, each with a kill bit.
  - wr_ptr/rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, 0..DEPTH.
- Request handshake:
  - req_valid = !rst && count != DEPTH.
  - req_pc = pc.
  - Issue = req_valid && req_ready. On issue: FIFO[wr_ptr] <= {pc, kill=redirect_valid}; wr_ptr++.
- PC update, in priority order:
  - rst -> RESET_PC.
  - redirect_valid -> redirect_pc with low log2(STEP) bits forced to 0.
  - issue -> pc + STEP, wrapping modulo 2^ADDR_WIDTH.
  - otherwise hold.
- Redirect: every FIFO entry valid at that edge gets kill=1. A request issued in the redirect cycle carries the old pc and is enqueued already killed.
- Response path (combinational):
  - head_kill = kill[rd_ptr].
  - out_valid = !rst && count != 0 && rsp_valid && !head_kill && !redirect_valid.
  - out_pc = FIFO[rd_ptr].pc; out_inst = rsp_inst.
  - rsp_ready = !rst && count != 0 && (out_ready || head_kill || redirect_valid).
  - Pop = rsp_valid && rsp_ready; rd_ptr++. A killed head, or any response arriving in a redirect cycle, is popped and dropped without ever raising out_valid.
- count: +1 on issue-only, -1 on pop-only, unchanged on both or neither.
- Empty (count==0): rsp_ready=0 and out_valid=0. A response arriving while empty is a protocol violation; it is not consumed.
- Full (count==DEPTH): req_valid=0. A pop in the same cycle does not re-enable req_valid until the next cycle; there is no bypass.

## Timing
- Reset values while rst is high: req_valid=0, rsp_ready=0, out_valid=0, req_pc=RESET_PC, count=0, ptrs=0, all kill bits 0.
- rst high mid-operation discards all in-flight state at the next edge. IFU responses for pre-reset requests must not be returned after reset.
- First cycle with rst low: req_valid=1, req_pc=RESET_PC.
- With req_ready held high and the FIFO not full: one request per cycle, PCs RESET_PC, +STEP, +2·STEP…
- Redirect latency: req_pc = redirect_pc in the cycle after redirect_valid.
- Response to decode: zero added latency. out_valid is in the same cycle as rsp_valid; backpressure from out_ready reaches rsp_ready combinationally.
- Max in-flight fetches = DEPTH. Throughput is 1 per cycle when IFU latency < DEPTH cycles.

## Test plan
- Reset release, req_ready=1, IFU replies 1 cycle later with inst=pc, out_ready=1:
  - req_pc sequence 0x20000000, 0x20000004, 0x20000008.
  - out_pc/out_inst pairs match, one per cycle.
- IFU never replies, req_ready=1:
  - exactly 4 issues (0x20000000..0x2000000C), then req_valid=0.
  - First response pops; req_valid=1 again the following cycle with 0x20000010.
- 3 requests outstanding, redirect_valid with redirect_pc=0x80000003:
  - next req_pc=0x80000000.
  - The 3 stale responses are drained with out_valid=0.
  - The first out_pc seen is 0x80000000.
- Redirect in the same cycle as an issue and a response:
  - issued entry enqueued killed; response dropped.
  - count unchanged (one push, one pop).
- out_ready=0 for 5 cycles with rsp_valid=1:
  - rsp_ready=0 and the head is held; out_pc stable.
  - Release: pairs delivered in order, none lost.
- rst asserted with 2 outstanding:
  - next cycle count=0, req_pc=0x20000000, out_valid=0.

Source files
------------

// File: rtl/ysyx_23060184_fetch_pcgen.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_fetch_pcgen
// Purpose  : Fetch-stage PC generator. Issues sequential fetch addresses over
//            a valid/ready request channel, remembers every issued PC in a
//            small in-order FIFO, and pairs each returned instruction with
//            its PC for decode. A redirect squashes all in-flight fetches;
//            their late responses are drained without reaching decode.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   redirect_valid/pc    branch/jump redirect (target aligned to STEP)
//   req_valid/ready/pc   fetch request channel to the IFU
//   rsp_valid/ready/inst in-order instruction response from the IFU
//   out_valid/ready      PC+instruction pair to decode
//   out_pc, out_inst
// ============================================================================
module ysyx_23060184_fetch_pcgen #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h2000_0000,
  parameter int                    STEP       = 4,
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_pc,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [31:0]           rsp_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [31:0]           out_inst
);

  localparam int                    PW      = $clog2(DEPTH);
  localparam logic [PW:0]           C_FULL  = (PW+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_STEP  = ADDR_WIDTH'(STEP);
  // Clears the low log2(STEP) bits of a redirect target.
  localparam logic [ADDR_WIDTH-1:0] C_ALIGN = ~(C_STEP - 1'b1);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_fifo_pc [DEPTH];
  logic [DEPTH-1:0]      r_kill;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_head_kill;
  logic [DEPTH-1:0]      w_live;

  assign w_full      = (r_count == C_FULL);
  assign w_empty     = (r_count == '0);
  assign w_head_kill = r_kill[r_rd_ptr];

  assign req_valid = !rst && !w_full;
  assign req_pc    = r_pc;
  assign w_issue   = req_valid && req_ready;

  // A response in a redirect cycle belongs to a squashed fetch, so it is
  // consumed and dropped just like a killed head.
  assign out_valid = !rst && !w_empty && rsp_valid && !w_head_kill && !redirect_valid;
  assign rsp_ready = !rst && !w_empty && (out_ready || w_head_kill || redirect_valid);
  assign out_pc    = r_fifo_pc[r_rd_ptr];
  assign out_inst  = rsp_inst;
  assign w_pop     = rsp_valid && rsp_ready;

  // Entry i holds an outstanding fetch when its distance from the read
  // pointer is below the occupancy count.
  always_comb begin
    w_live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_live[i] = {1'b0, PW'(PW'(i) - r_rd_ptr)} < r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (redirect_valid) begin
        r_pc <= redirect_pc & C_ALIGN;
      end else if (w_issue) begin
        r_pc <= r_pc + C_STEP;
      end
      if (w_issue) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Kill bits: a request issued alongside a redirect carries the old PC and
  // is enqueued already killed; every other live entry is killed by the
  // redirect. The written slot is never live because issue implies not full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kill <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_issue && (r_wr_ptr == PW'(i))) begin
          r_kill[i] <= redirect_valid;
        end else if (redirect_valid && w_live[i]) begin
          r_kill[i] <= 1'b1;
        end
      end
    end
  end

  // PC storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_fifo_pc[r_wr_ptr] <= r_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060184_fetch_pcgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060184_fetch_pcgen
// Purpose  : Self-checking bench for the fetch PC generator: a table of
//            per-cycle vectors followed by directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060184_fetch_pcgen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_pc;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060184_fetch_pcgen dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_pc         (req_pc),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_inst       (rsp_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rq;
    logic        sv;
    logic [31:0] inst;
    logic        ordy;
    logic        e_reqv;
    logic [31:0] e_pc;
    logic        e_rspr;
    logic        e_outv;
    logic [31:0] e_opc;
    logic [31:0] e_oinst;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then let them settle.
  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic rq, input logic sv, input logic [31:0] inst,
                       input logic ordy);
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    req_ready      = rq;
    rsp_valid      = sv;
    rsp_inst       = inst;
    out_ready      = ordy;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
  endtask

  vec_t tbl[6];
  int   n_iss;

  initial begin
    // Reset release, IFU replies one cycle later with inst = pc.
    tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
               1'b0, 32'h2000_0000, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1,
               1'b1, 32'h2000_0000, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2000_0000, 1'b1,
               1'b1, 32'h2000_0004, 1'b1, 1'b1, 32'h2000_0000, 32'h2000_0000};
    tbl[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2000_0004, 1'b1,
               1'b1, 32'h2000_0008, 1'b1, 1'b1, 32'h2000_0004, 32'h2000_0004};
    tbl[4] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2000_0008, 1'b1,
               1'b1, 32'h2000_000C, 1'b1, 1'b1, 32'h2000_0008, 32'h2000_0008};
    // Response while empty: not consumed, never forwarded.
    tbl[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1,
               1'b1, 32'h2000_000C, 1'b0, 1'b0, 32'h0, 32'h0};

    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(tbl[k].rst, tbl[k].rv, tbl[k].rpc, tbl[k].rq, tbl[k].sv,
            tbl[k].inst, tbl[k].ordy);
      chk($sformatf("v%0d req_valid", k), 32'(req_valid), 32'(tbl[k].e_reqv));
      chk($sformatf("v%0d req_pc", k), req_pc, tbl[k].e_pc);
      chk($sformatf("v%0d rsp_ready", k), 32'(rsp_ready), 32'(tbl[k].e_rspr));
      chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(tbl[k].e_outv));
      if (tbl[k].e_outv) begin
        chk($sformatf("v%0d out_pc", k), out_pc, tbl[k].e_opc);
        chk($sformatf("v%0d out_inst", k), out_inst, tbl[k].e_oinst);
      end
    end

    // IFU never replies: four issues, then stall until a pop.
    do_reset();
    n_iss = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      if (req_valid) begin
        chk("full_seq req_pc", req_pc, 32'h2000_0000 + 32'(4 * n_iss));
        n_iss++;
      end
    end
    chk("full issue count", 32'(n_iss), 32'd4);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_0000, 1'b1);
    chk("full pop out_valid", 32'(out_valid), 32'd1);
    chk("full pop out_pc", out_pc, 32'h2000_0000);
    chk("full no bypass req_valid", 32'(req_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("after pop req_valid", 32'(req_valid), 32'd1);
    chk("after pop req_pc", req_pc, 32'h2000_0010);

    // Redirect with three outstanding fetches.
    do_reset();
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h8000_0003, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_0000 + 32'(k), 1'b0);
      chk($sformatf("drain%0d req_pc", k), req_pc, 32'h8000_0000);
      chk($sformatf("drain%0d rsp_ready", k), 32'(rsp_ready), 32'd1);
      chk($sformatf("drain%0d out_valid", k), 32'(out_valid), 32'd0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("drained rsp_ready", 32'(rsp_ready), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1234, 1'b1);
    chk("post redir out_valid", 32'(out_valid), 32'd1);
    chk("post redir out_pc", out_pc, 32'h8000_0000);
    chk("post redir out_inst", out_inst, 32'h0000_1234);

    // Redirect coinciding with an issue and a response.
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h4000_0000, 1'b1, 1'b1, 32'h2000_0000, 1'b1);
    chk("coinc out_valid", 32'(out_valid), 32'd0);
    chk("coinc rsp_ready", 32'(rsp_ready), 32'd1);
    chk("coinc req_valid", 32'(req_valid), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2000_0004, 1'b0);
    chk("coinc next req_pc", req_pc, 32'h4000_0000);
    chk("coinc killed rsp_ready", 32'(rsp_ready), 32'd1);
    chk("coinc killed out_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    chk("coinc empty rsp_ready", 32'(rsp_ready), 32'd0);

    // Decode backpressure for five cycles.
    do_reset();
    repeat (2) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0000, 1'b0);
      chk($sformatf("bp%0d rsp_ready", k), 32'(rsp_ready), 32'd0);
      chk($sformatf("bp%0d out_pc", k), out_pc, 32'h2000_0000);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0000, 1'b1);
    chk("bp rel0 out_valid", 32'(out_valid), 32'd1);
    chk("bp rel0 out_pc", out_pc, 32'h2000_0000);
    chk("bp rel0 out_inst", out_inst, 32'hAAAA_0000);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBB_0000, 1'b1);
    chk("bp rel1 out_valid", 32'(out_valid), 32'd1);
    chk("bp rel1 out_pc", out_pc, 32'h2000_0004);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCCCC_0000, 1'b1);
    chk("bp empty rsp_ready", 32'(rsp_ready), 32'd0);

    // Reset with two outstanding fetches.
    do_reset();
    repeat (2) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
    chk("rst req_valid", 32'(req_valid), 32'd0);
    chk("rst rsp_ready", 32'(rsp_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2000_0008, 1'b1);
    chk("post rst req_pc", req_pc, 32'h2000_0000);
    chk("post rst req_valid", 32'(req_valid), 32'd1);
    chk("post rst out_valid", 32'(out_valid), 32'd0);
    chk("post rst rsp_ready", 32'(rsp_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
